output_preprocessor: RTL and testbench
======================================

Name: output_preprocessor

Overview:
- Sits directly downstream of the router; consumes its packed output channels.
- Per channel: adds a programmable offset with saturation, then clamps to a programmable [min,max] window.
- Round-robin arbiter serialises pending channels onto a single valid/ready stream toward the DAC/DDS drivers.
- Per-channel offset/min/max are written from the frontpanel controller.

Parameters:
- W_CHAN, 16, width of each channel word (signed two's complement)
- W_SEL, 4, width of channel index
- N_OUT, 8, number of channels (N_OUT <= 2^W_SEL)

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- data_packed_in  input  W_CHAN*N_OUT  router output; channel i at [i*W_CHAN +: W_CHAN]
- data_valid_in  input  N_OUT  one-cycle strobe per channel: new sample present
- param_chan_in  input  W_SEL  channel addressed by a parameter write
- offset_in  input  W_CHAN  signed offset to store
- min_in  input  W_CHAN  signed lower bound to store
- max_in  input  W_CHAN  signed upper bound to store
- param_wr_in  input  1  one-cycle write strobe; stores offset/min/max for param_chan_in
- dac_data_out  output  W_CHAN  processed sample
- dac_chan_out  output  W_SEL  channel index of dac_data_out
- dac_valid_out  output  1  output word valid
- dac_ready_in  input  1  downstream accepts the word

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n_in; all state is cleared per channel.
- Reset values:
  - offset = 0, min = -2^(W_CHAN-1), max = 2^(W_CHAN-1)-1.
  - Sample registers and pending flags = 0.
  - dac_data_out = 0, dac_chan_out = 0, dac_valid_out = 0.
  - Arbiter pointer = N_OUT-1, so channel 0 has first priority.
  - FSM in IDLE.
- Capture: data_valid_in[i]=1 latches that channel's word and sets pending[i]. A strobe on an already-pending channel overwrites the sample (latest wins); only one output is produced.
- Parameter writes:
  - A write with param_chan_in >= N_OUT is ignored.
  - Writes take effect the next cycle.
  - A channel already inside the pipeline uses the parameters snapshotted at grant.
- FSM, one word in flight:
  - IDLE: if any pending, grant the first pending channel searching from pointer+1 (wrapping). Snapshot its sample and parameters, clear its pending flag, set pointer=grant, go to ADD.
  - ADD: sum = sample + offset in W_CHAN+1 bits, saturated to the W_CHAN signed range. Go to CLAMP.
  - CLAMP:
    - if sum < min, result = min; else if sum > max, result = max; else result = sum.
    - If min > max, the min test wins.
    - Register dac_data_out and dac_chan_out, assert dac_valid_out, go to SEND.
  - SEND: hold data, channel and valid stable until dac_ready_in=1. On that cycle deassert valid and go to IDLE.
- Latency: strobe at cycle T with FSM idle -> pending at T+1 -> grant at T+1 -> dac_valid_out high from T+4. Minimum spacing between words is 4 cycles with ready tied high.
- Simultaneous events:
  - A strobe on the channel being granted in the same cycle: the new sample is captured and pending stays set, so the channel is re-sent later.
  - A strobe during ADD/CLAMP/SEND for the in-flight channel sets pending again.
- dac_ready_in is ignored outside SEND.
- Reset mid-operation drops any in-flight word and all pending flags; dac_valid_out falls asynchronously.

Optional Feature:
- Macro: OPP_OVERRUN_COUNT_EN.
- Defined:
  - Adds output port overrun_count_out [15:0], reset 0.
  - Increments by 1 in any cycle where at least one data_valid_in bit hits a channel whose pending flag is already set.
  - Saturates at 0xFFFF.
  - Cleared by a param_wr_in with param_chan_in = all ones.
- Not defined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Reset defaults, ready=1: strobe ch2 with 0x1234 -> dac_chan_out=2, dac_data_out=0x1234, valid 3 cycles after the pending cycle, single word.
- Offset saturation: ch0 offset=0x7000, sample=0x2000 -> output 0x7FFF. Offset=-0x7000 (0x9000), sample=0x9000 -> output 0x8000.
- Clamp: ch1 min=-100, max=100; samples 500, -500, 42 -> outputs 100, -100, 42. Then min=10, max=5, sample 7 -> output 10.
- Round-robin: strobe ch1, ch3 and ch6 in the same cycle, ready=1 -> order 1, 3, 6. Strobe ch0 and ch3 while ch6 is in SEND -> order 0, 3.
- Backpressure: ready=0 for 20 cycles in SEND -> data, channel and valid stable throughout. Strobing ch5 twice (0x0001 then 0x0002) meanwhile yields a single ch5 word 0x0002 after the handshake. With OPP_OVERRUN_COUNT_EN, the counter reads 1.
- Reset mid-SEND: drop rst_n_in while valid=1 -> valid=0 immediately. After release, no output appears until a new strobe arrives.

Source files
------------

// File: rtl/output_preprocessor.sv
// output_preprocessor: per-channel offset (saturating) + [min,max] clamp, with a
// round-robin arbiter serialising pending channels onto one valid/ready stream.
// Optional build macro OPP_OVERRUN_COUNT_EN adds overrun_count_out[15:0].

// Per-channel state: latest sample, pending flag and the stored parameters.
module opp_chan #(
    parameter int W_CHAN = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              strobe_in,
    input  logic [W_CHAN-1:0] data_in,
    input  logic              wr_in,
    input  logic [W_CHAN-1:0] offset_in,
    input  logic [W_CHAN-1:0] min_in,
    input  logic [W_CHAN-1:0] max_in,
    input  logic              clr_in,
    output logic [W_CHAN-1:0] sample_out,
    output logic              pending_out,
    output logic [W_CHAN-1:0] offset_out,
    output logic [W_CHAN-1:0] min_out,
    output logic [W_CHAN-1:0] max_out
);
    localparam logic [W_CHAN-1:0] MIN_RST = {1'b1, {(W_CHAN-1){1'b0}}};
    localparam logic [W_CHAN-1:0] MAX_RST = {1'b0, {(W_CHAN-1){1'b1}}};

    logic [W_CHAN-1:0] sample_q, sample_d, offset_q, offset_d, min_q, min_d, max_q, max_d;
    logic              pending_q, pending_d;

    // Next state: a strobe beats a grant clear so a same-cycle sample is re-sent.
    always_comb begin
        sample_d  = sample_q;
        pending_d = pending_q;
        offset_d  = offset_q;
        min_d     = min_q;
        max_d     = max_q;
        if (strobe_in) begin
            sample_d  = data_in;
            pending_d = 1'b1;
        end else if (clr_in) begin
            pending_d = 1'b0;
        end
        if (wr_in) begin
            offset_d = offset_in;
            min_d    = min_in;
            max_d    = max_in;
        end
    end

    // Channel registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sample_q  <= '0;
            pending_q <= 1'b0;
            offset_q  <= '0;
            min_q     <= MIN_RST;
            max_q     <= MAX_RST;
        end else begin
            sample_q  <= sample_d;
            pending_q <= pending_d;
            offset_q  <= offset_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    assign sample_out  = sample_q;
    assign pending_out = pending_q;
    assign offset_out  = offset_q;
    assign min_out     = min_q;
    assign max_out     = max_q;
endmodule

module output_preprocessor #(
    parameter int W_CHAN = 16,
    parameter int W_SEL  = 4,
    parameter int N_OUT  = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [W_CHAN*N_OUT-1:0] data_packed_in,
    input  logic [N_OUT-1:0]        data_valid_in,
    input  logic [W_SEL-1:0]        param_chan_in,
    input  logic [W_CHAN-1:0]       offset_in,
    input  logic [W_CHAN-1:0]       min_in,
    input  logic [W_CHAN-1:0]       max_in,
    input  logic                    param_wr_in,
    output logic [W_CHAN-1:0]       dac_data_out,
    output logic [W_SEL-1:0]        dac_chan_out,
    output logic                    dac_valid_out,
`ifdef OPP_OVERRUN_COUNT_EN
    output logic [15:0]             overrun_count_out,
`endif
    input  logic                    dac_ready_in
);
    localparam logic [W_CHAN-1:0] SMAX = {1'b0, {(W_CHAN-1){1'b1}}};
    localparam logic [W_CHAN-1:0] SMIN = {1'b1, {(W_CHAN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_CLAMP, S_SEND} state_t;

    logic [N_OUT-1:0][W_CHAN-1:0] sample, offs, mins, maxs;
    logic [N_OUT-1:0]             pending, chan_wr, chan_clr;

    state_t            state_q, state_d;
    logic [W_SEL-1:0]  ptr_q, ptr_d, snap_chan_q, snap_chan_d;
    logic [W_CHAN-1:0] snap_sample_q, snap_sample_d, snap_off_q, snap_off_d;
    logic [W_CHAN-1:0] snap_min_q, snap_min_d, snap_max_q, snap_max_d;
    logic [W_CHAN-1:0] sum_q, sum_d, dac_data_q, dac_data_d;
    logic [W_SEL-1:0]  dac_chan_q, dac_chan_d;
    logic              dac_valid_q, dac_valid_d;

    logic              grant_found, grant_fire;
    logic [W_SEL-1:0]  grant_idx;
    logic [W_CHAN:0]   sum_wide;
    logic [W_CHAN-1:0] sum_sat, clamp_res;

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_chan
            assign chan_wr[g]  = param_wr_in && (param_chan_in == W_SEL'(g));
            assign chan_clr[g] = grant_fire && (grant_idx == W_SEL'(g));
            opp_chan #(.W_CHAN(W_CHAN)) u_chan (
                .clk_in     (clk_in),
                .rst_n_in   (rst_n_in),
                .strobe_in  (data_valid_in[g]),
                .data_in    (data_packed_in[g*W_CHAN +: W_CHAN]),
                .wr_in      (chan_wr[g]),
                .offset_in  (offset_in),
                .min_in     (min_in),
                .max_in     (max_in),
                .clr_in     (chan_clr[g]),
                .sample_out (sample[g]),
                .pending_out(pending[g]),
                .offset_out (offs[g]),
                .min_out    (mins[g]),
                .max_out    (maxs[g])
            );
        end
    endgenerate

    // Round-robin pick: first pending channel after the pointer; scanning from the
    // far end down lets the nearest candidate overwrite the others.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_OUT; k >= 1; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % N_OUT;
            if (pending[idx]) begin
                grant_found = 1'b1;
                grant_idx   = W_SEL'(idx);
            end
        end
    end

    assign grant_fire = (state_q == S_IDLE) && grant_found;

    // Saturating add in one extra bit, then signed clamp with the min test first.
    always_comb begin
        sum_wide = {snap_sample_q[W_CHAN-1], snap_sample_q} + {snap_off_q[W_CHAN-1], snap_off_q};
        if (sum_wide[W_CHAN] != sum_wide[W_CHAN-1])
            sum_sat = sum_wide[W_CHAN] ? SMIN : SMAX;
        else
            sum_sat = sum_wide[W_CHAN-1:0];
        if ($signed(sum_q) < $signed(snap_min_q))
            clamp_res = snap_min_q;
        else if ($signed(sum_q) > $signed(snap_max_q))
            clamp_res = snap_max_q;
        else
            clamp_res = sum_q;
    end

    // FSM next-state and datapath: one word in flight.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        snap_chan_d   = snap_chan_q;
        snap_sample_d = snap_sample_q;
        snap_off_d    = snap_off_q;
        snap_min_d    = snap_min_q;
        snap_max_d    = snap_max_q;
        sum_d         = sum_q;
        dac_data_d    = dac_data_q;
        dac_chan_d    = dac_chan_q;
        dac_valid_d   = dac_valid_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    snap_chan_d   = grant_idx;
                    snap_sample_d = sample[grant_idx];
                    snap_off_d    = offs[grant_idx];
                    snap_min_d    = mins[grant_idx];
                    snap_max_d    = maxs[grant_idx];
                    ptr_d         = grant_idx;
                    state_d       = S_ADD;
                end
            end
            S_ADD: begin
                sum_d   = sum_sat;
                state_d = S_CLAMP;
            end
            S_CLAMP: begin
                dac_data_d  = clamp_res;
                dac_chan_d  = snap_chan_q;
                dac_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (dac_ready_in) begin
                    dac_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= S_IDLE;
            ptr_q         <= W_SEL'(N_OUT - 1);
            snap_chan_q   <= '0;
            snap_sample_q <= '0;
            snap_off_q    <= '0;
            snap_min_q    <= '0;
            snap_max_q    <= '0;
            sum_q         <= '0;
            dac_data_q    <= '0;
            dac_chan_q    <= '0;
            dac_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            snap_chan_q   <= snap_chan_d;
            snap_sample_q <= snap_sample_d;
            snap_off_q    <= snap_off_d;
            snap_min_q    <= snap_min_d;
            snap_max_q    <= snap_max_d;
            sum_q         <= sum_d;
            dac_data_q    <= dac_data_d;
            dac_chan_q    <= dac_chan_d;
            dac_valid_q   <= dac_valid_d;
        end
    end

    assign dac_data_out  = dac_data_q;
    assign dac_chan_out  = dac_chan_q;
    assign dac_valid_out = dac_valid_q;

`ifdef OPP_OVERRUN_COUNT_EN
    logic [15:0] ovr_q, ovr_d;

    // Count cycles where a strobe lands on an already-pending channel; clear wins.
    always_comb begin
        ovr_d = ovr_q;
        if (param_wr_in && (param_chan_in == {W_SEL{1'b1}}))
            ovr_d = '0;
        else if (|(data_valid_in & pending) && (ovr_q != 16'hFFFF))
            ovr_d = ovr_q + 16'd1;
    end

    // Overrun counter register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) ovr_q <= '0;
        else           ovr_q <= ovr_d;
    end

    assign overrun_count_out = ovr_q;
`endif
endmodule

// File: tb/tb_output_preprocessor.sv
// Directed bench for output_preprocessor with hand-computed expected words.
module tb_output_preprocessor;
    logic         clk_in = 1'b0;
    logic         rst_n_in = 1'b0;
    logic [127:0] data_packed_in = '0;
    logic [7:0]   data_valid_in = '0;
    logic [3:0]   param_chan_in = '0;
    logic [15:0]  offset_in = '0, min_in = '0, max_in = '0;
    logic         param_wr_in = 1'b0;
    logic [15:0]  dac_data_out;
    logic [3:0]   dac_chan_out;
    logic         dac_valid_out;
    logic         dac_ready_in = 1'b1;
`ifdef OPP_OVERRUN_COUNT_EN
    logic [15:0]  overrun_count_out;
`endif

    int errors = 0;
    int checks = 0;

    output_preprocessor dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .data_packed_in(data_packed_in), .data_valid_in(data_valid_in),
        .param_chan_in(param_chan_in), .offset_in(offset_in),
        .min_in(min_in), .max_in(max_in), .param_wr_in(param_wr_in),
        .dac_data_out(dac_data_out), .dac_chan_out(dac_chan_out),
        .dac_valid_out(dac_valid_out),
`ifdef OPP_OVERRUN_COUNT_EN
        .overrun_count_out(overrun_count_out),
`endif
        .dac_ready_in(dac_ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic strobe(input int ch, input logic [15:0] v);
        data_packed_in[ch*16 +: 16] = v;
        data_valid_in[ch] = 1'b1;
        tick();
        data_valid_in = '0;
    endtask

    task automatic setp(input logic [3:0] ch, input logic [15:0] off, input logic [15:0] mn,
                        input logic [15:0] mx);
        param_chan_in = ch;
        offset_in     = off;
        min_in        = mn;
        max_in        = mx;
        param_wr_in   = 1'b1;
        tick();
        param_wr_in   = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!dac_valid_out && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, {15'd0, dac_valid_out}, 16'd1);
    endtask

    // Waits for a word, checks it, and lets the ready=1 handshake consume it.
    task automatic expect_word(input string tag, input logic [3:0] ch, input logic [15:0] d);
        wait_valid(tag);
        chk({tag, "_ch"}, {12'd0, dac_chan_out}, {12'd0, ch});
        chk({tag, "_data"}, dac_data_out, d);
        tick();
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (dac_valid_out) seen = 1'b1;
            tick();
        end
        chk(tag, {15'd0, seen}, 16'd0);
    endtask

    initial begin
        logic [15:0] d0;
        logic [3:0]  c0;
        logic        stable;

        // Reset state
        #2;
        chk("rst_valid", {15'd0, dac_valid_out}, 16'd0);
        chk("rst_data", dac_data_out, 16'h0000);
        chk("rst_chan", {12'd0, dac_chan_out}, 16'd0);
        do_reset();

        // Default parameters pass the sample through; exact latency
        strobe(2, 16'h1234);
        tick();
        tick();
        chk("lat_early", {15'd0, dac_valid_out}, 16'd0);
        tick();
        chk("lat_on", {15'd0, dac_valid_out}, 16'd1);
        chk("lat_ch", {12'd0, dac_chan_out}, 16'd2);
        chk("lat_data", dac_data_out, 16'h1234);
        tick();
        quiet("single_word", 8);

        // Offset saturation both directions
        setp(0, 16'h7000, 16'h8000, 16'h7FFF);
        strobe(0, 16'h2000);
        expect_word("sat_pos", 0, 16'h7FFF);
        setp(0, 16'h9000, 16'h8000, 16'h7FFF);
        strobe(0, 16'h9000);
        expect_word("sat_neg", 0, 16'h8000);

        // Clamp window, then inverted window where min wins
        setp(1, 16'h0000, 16'hFF9C, 16'h0064);
        strobe(1, 16'h01F4);
        expect_word("clamp_hi", 1, 16'h0064);
        strobe(1, 16'hFE0C);
        expect_word("clamp_lo", 1, 16'hFF9C);
        strobe(1, 16'h002A);
        expect_word("clamp_in", 1, 16'h002A);
        setp(1, 16'h0000, 16'h000A, 16'h0005);
        strobe(1, 16'h0007);
        expect_word("clamp_inv", 1, 16'h000A);

        // Round-robin from a fresh pointer
        do_reset();
        data_packed_in[1*16 +: 16] = 16'h0111;
        data_packed_in[3*16 +: 16] = 16'h0333;
        data_packed_in[6*16 +: 16] = 16'h0666;
        data_valid_in = 8'b0100_1010;
        tick();
        data_valid_in = '0;
        expect_word("rr1", 1, 16'h0111);
        expect_word("rr3", 3, 16'h0333);
        wait_valid("rr6");
        chk("rr6_ch", {12'd0, dac_chan_out}, 16'd6);
        chk("rr6_data", dac_data_out, 16'h0666);
        dac_ready_in = 1'b0;
        data_packed_in[0*16 +: 16] = 16'h0AAA;
        data_packed_in[3*16 +: 16] = 16'h0BBB;
        data_valid_in = 8'b0000_1001;
        tick();
        data_valid_in = '0;
        dac_ready_in = 1'b1;
        tick();
        expect_word("rr0", 0, 16'h0AAA);
        expect_word("rr3b", 3, 16'h0BBB);

        // Backpressure: word held stable, ch5 collapses to latest sample
        strobe(4, 16'h4444);
        wait_valid("bp4");
        dac_ready_in = 1'b0;
        d0 = dac_data_out;
        c0 = dac_chan_out;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                data_packed_in[5*16 +: 16] = 16'h0001;
                data_valid_in[5] = 1'b1;
            end
            if (i == 8) begin
                data_packed_in[5*16 +: 16] = 16'h0002;
                data_valid_in[5] = 1'b1;
            end
            tick();
            data_valid_in = '0;
            if (!dac_valid_out || dac_data_out !== d0 || dac_chan_out !== c0) stable = 1'b0;
        end
        chk("bp_stable", {15'd0, stable}, 16'd1);
        chk("bp_data", d0, 16'h4444);
        chk("bp_ch", {12'd0, c0}, 16'd4);
`ifdef OPP_OVERRUN_COUNT_EN
        chk("ovr_count", overrun_count_out, 16'd1);
        setp(4'hF, 16'h0000, 16'h8000, 16'h7FFF);
        chk("ovr_clear", overrun_count_out, 16'd0);
`endif
        dac_ready_in = 1'b1;
        tick();
        expect_word("bp5", 5, 16'h0002);
        quiet("bp_single", 8);

        // Reset in SEND drops the word and any pending channel
        strobe(2, 16'h2222);
        wait_valid("rs2");
        dac_ready_in = 1'b0;
        strobe(3, 16'h3333);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("rs_async", {15'd0, dac_valid_out}, 16'd0);
        tick();
        rst_n_in = 1'b1;
        dac_ready_in = 1'b1;
        tick();
        quiet("rs_quiet", 10);

        // Out-of-range write ignored; fresh strobe still flows
        setp(4'd8, 16'h0100, 16'h0000, 16'h0001);
        strobe(0, 16'h0005);
        expect_word("bad_wr", 0, 16'h0005);
        strobe(7, 16'h0777);
        expect_word("rs_new", 7, 16'h0777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
